// File: rtl/pll_pkg.sv
// pll_pkg: shared widths, loop-filter rail values and FSM state type for the PLL error processing unit
package pll_pkg;
  localparam int ERR_SIZE = 8;
  localparam int CNT_SIZE = 8;
  localparam int ERR_POS_RAIL = 127;
  localparam int ERR_NEG_RAIL = -128;
  typedef enum logic [1:0] {FREQ_ACQ, PHASE_TRACK, LOCKED} epu_state_t;
endpackage

// File: rtl/epu_lock_det.sv
// epu_lock_det: phase-lock window counters (ports: clk/rst, i_en, i_clr, i_locked, i_valid, i_err, thresholds in; o_lock_hit/o_unlock_hit pulses out)
module epu_lock_det #(
  parameter int ERR_SIZE = 8,
  parameter int CNT_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic                i_locked,
  input  logic                i_valid,
  input  logic [ERR_SIZE-1:0] i_err,
  input  logic [CNT_SIZE-1:0] i_thresh,
  input  logic [CNT_SIZE-1:0] i_lock_cnt,
  input  logic [CNT_SIZE-1:0] i_unlock_cnt,
  output logic                o_lock_hit,
  output logic                o_unlock_hit
);
  localparam int CW = ERR_SIZE > CNT_SIZE ? ERR_SIZE : CNT_SIZE;
  logic [CNT_SIZE-1:0] r_win, r_miss;
  logic [CNT_SIZE-1:0] w_win_next, w_miss_next, w_lc, w_uc;
  logic [ERR_SIZE-1:0] w_abs;
  logic                w_in;
  assign w_abs = i_err[ERR_SIZE-1] ? -i_err : i_err;
  assign w_in = CW'(w_abs) <= CW'(i_thresh);
  assign w_lc = (i_lock_cnt == '0) ? CNT_SIZE'(1) : i_lock_cnt;
  assign w_uc = (i_unlock_cnt == '0) ? CNT_SIZE'(1) : i_unlock_cnt;
  assign w_win_next = i_locked ? '0 : !i_valid ? r_win : !w_in ? '0 : (&r_win) ? r_win : r_win + 1'b1;
  assign w_miss_next = !i_locked ? '0 : !i_valid ? r_miss : w_in ? '0 : (&r_miss) ? r_miss : r_miss + 1'b1;
  assign o_lock_hit = i_en && !i_clr && !i_locked && (w_win_next >= w_lc);
  assign o_unlock_hit = i_en && !i_clr && i_locked && (w_miss_next >= w_uc);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
      r_miss <= '0;
    end else if (i_en) begin
      r_win <= (i_clr || o_lock_hit || o_unlock_hit) ? '0 : w_win_next;
      r_miss <= (i_clr || o_lock_hit || o_unlock_hit) ? '0 : w_miss_next;
    end
  end
endmodule

// File: rtl/pll_epu.sv
// pll_epu: ADPLL error processing unit (in: clk_ref, rst, VDD/VSS, enable, tdc_val/tdc_valid, f_slow/f_fast, lock thresholds; out: lf_err, lf_en, freq_locked, phase_locked)
module pll_epu #(
  parameter int ERR_SIZE = pll_pkg::ERR_SIZE,
  parameter int CNT_SIZE = pll_pkg::CNT_SIZE,
  parameter int FREQ_SETTLE = 16,
  parameter int SLIP_COUNT = 4
) (
  input  logic                clk_ref,
  input  logic                rst,
  input  logic                VDD,
  input  logic                VSS,
  input  logic                enable,
  input  logic [ERR_SIZE-1:0] tdc_val,
  input  logic                tdc_valid,
  input  logic                f_slow,
  input  logic                f_fast,
  input  logic [CNT_SIZE-1:0] lock_thresh,
  input  logic [CNT_SIZE-1:0] lock_count,
  input  logic [CNT_SIZE-1:0] unlock_count,
  output logic [ERR_SIZE-1:0] lf_err,
  output logic                lf_en,
  output logic                freq_locked,
  output logic                phase_locked
);
  import pll_pkg::*;
  localparam int SW = $clog2(FREQ_SETTLE + 1);
  localparam int PW = $clog2(SLIP_COUNT + 1);
  localparam logic [ERR_SIZE-1:0] W_POS = ERR_SIZE'(ERR_POS_RAIL);
  localparam logic [ERR_SIZE-1:0] W_NEG = ERR_SIZE'(ERR_NEG_RAIL);
  localparam logic [ERR_SIZE-1:0] W_NEG_CLIP = ERR_SIZE'(ERR_NEG_RAIL + 1);
  epu_state_t          r_state;
  logic [SW-1:0]       r_settle;
  logic [PW-1:0]       r_slip;
  logic [ERR_SIZE-1:0] r_err;
  logic                r_en, r_freq, r_phase;
  logic [SW-1:0]       w_settle_inc;
  logic [PW-1:0]       w_slip_inc;
  logic [ERR_SIZE-1:0] w_clip, w_rail;
  logic                w_acq, w_xor, w_settled, w_slip, w_lock_hit, w_unlock_hit, w_unused;
  assign w_unused = &{1'b0, VDD, VSS};
  assign w_acq = r_state == FREQ_ACQ;
  assign w_xor = f_slow ^ f_fast;
  assign w_rail = f_slow ? W_POS : W_NEG;
  assign w_clip = (tdc_val == W_NEG) ? W_NEG_CLIP : tdc_val;
  assign w_settle_inc = r_settle + 1'b1;
  assign w_slip_inc = r_slip + 1'b1;
  assign w_settled = w_acq && !f_slow && !f_fast && (w_settle_inc == SW'(FREQ_SETTLE));
  assign w_slip = !w_acq && w_xor && (w_slip_inc == PW'(SLIP_COUNT));
  epu_lock_det #(.ERR_SIZE(ERR_SIZE), .CNT_SIZE(CNT_SIZE)) u_lock_det (
    .clk          (clk_ref),
    .rst          (rst),
    .i_en         (enable),
    .i_clr        (w_acq || w_slip),
    .i_locked     (r_state == LOCKED),
    .i_valid      (tdc_valid),
    .i_err        (w_clip),
    .i_thresh     (lock_thresh),
    .i_lock_cnt   (lock_count),
    .i_unlock_cnt (unlock_count),
    .o_lock_hit   (w_lock_hit),
    .o_unlock_hit (w_unlock_hit)
  );
  // A slip cycle behaves like acquisition so the rail reaches the loop filter on that edge.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_state <= FREQ_ACQ;
      r_settle <= '0;
      r_slip <= '0;
      r_err <= '0;
      r_en <= 1'b0;
      r_freq <= 1'b0;
      r_phase <= 1'b0;
    end else if (!enable) begin
      r_en <= 1'b0;
    end else if (w_acq || w_slip) begin
      r_err <= w_xor ? w_rail : '0;
      r_en <= w_xor;
      r_slip <= '0;
      r_settle <= (!w_acq || w_settled || f_slow || f_fast) ? '0 : w_settle_inc;
      r_state <= w_settled ? PHASE_TRACK : FREQ_ACQ;
      r_freq <= w_settled;
      r_phase <= 1'b0;
    end else begin
      r_err <= tdc_valid ? w_clip : r_err;
      r_en <= tdc_valid;
      r_slip <= w_xor ? w_slip_inc : '0;
      r_state <= w_lock_hit ? LOCKED : w_unlock_hit ? PHASE_TRACK : r_state;
      r_phase <= w_lock_hit || (r_phase && !w_unlock_hit);
    end
  end
  assign lf_err = r_err;
  assign lf_en = r_en;
  assign freq_locked = r_freq;
  assign phase_locked = r_phase;
endmodule

// File: tb/tb_pll_epu.sv
// tb_pll_epu: directed plus randomized check of pll_epu against a behavioural model
module tb_pll_epu;
  logic clk_ref = 1'b0;
  logic rst, enable, tdc_valid, f_slow, f_fast;
  logic VDD = 1'b1;
  logic VSS = 1'b0;
  logic [7:0] tdc_val, lock_thresh, lock_count, unlock_count, lf_err;
  logic lf_en, freq_locked, phase_locked;
  int n_checks = 0;
  int n_err = 0;
  int m_mode = 0;
  int m_settle = 0;
  int m_slip = 0;
  int m_win = 0;
  int m_miss = 0;
  int m_err = 0;
  bit m_en = 1'b0;
  localparam int SETTLE = 16;
  localparam int SLIP = 4;
  pll_epu dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .VDD          (VDD),
    .VSS          (VSS),
    .enable       (enable),
    .tdc_val      (tdc_val),
    .tdc_valid    (tdc_valid),
    .f_slow       (f_slow),
    .f_fast       (f_fast),
    .lock_thresh  (lock_thresh),
    .lock_count   (lock_count),
    .unlock_count (unlock_count),
    .lf_err       (lf_err),
    .lf_en        (lf_en),
    .freq_locked  (freq_locked),
    .phase_locked (phase_locked)
  );
  always #5 clk_ref = ~clk_ref;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_counts();
    m_settle = 0;
    m_slip = 0;
    m_win = 0;
    m_miss = 0;
  endtask
  task automatic model_step();
    int clip, mag, lc, uc;
    bit one_rail, in_win;
    if (rst) begin
      m_mode = 0;
      m_err = 0;
      m_en = 0;
      clear_counts();
      return;
    end
    if (!enable) begin
      m_en = 0;
      return;
    end
    one_rail = f_slow != f_fast;
    clip = int'($signed(tdc_val));
    if (clip == -128) clip = -127;
    mag = clip < 0 ? -clip : clip;
    in_win = mag <= int'(lock_thresh);
    lc = lock_count == 0 ? 1 : int'(lock_count);
    uc = unlock_count == 0 ? 1 : int'(unlock_count);
    if (m_mode == 0) begin
      m_err = one_rail ? (f_slow ? 127 : -128) : 0;
      m_en = one_rail;
      m_settle = (f_slow || f_fast) ? 0 : m_settle + 1;
      if (m_settle == SETTLE) begin
        m_mode = 1;
        clear_counts();
      end
    end else begin
      m_slip = one_rail ? m_slip + 1 : 0;
      if (m_slip == SLIP) begin
        m_err = f_slow ? 127 : -128;
        m_en = 1;
        m_mode = 0;
        clear_counts();
      end else begin
        m_en = tdc_valid;
        if (tdc_valid) begin
          m_err = clip;
          if (m_mode == 1) m_win = in_win ? (m_win < 255 ? m_win + 1 : 255) : 0;
          else m_miss = in_win ? 0 : (m_miss < 255 ? m_miss + 1 : 255);
        end
        if (m_mode == 1 && m_win >= lc) begin
          m_mode = 2;
          m_win = 0;
          m_miss = 0;
        end else if (m_mode == 2 && m_miss >= uc) begin
          m_mode = 1;
          m_win = 0;
          m_miss = 0;
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk_ref);
    model_step();
    #1;
    chk("lf_err", 32'(lf_err), 32'(m_err & 255));
    chk("lf_en", 32'(lf_en), 32'(m_en));
    chk("freq_locked", 32'(freq_locked), 32'(m_mode != 0));
    chk("phase_locked", 32'(phase_locked), 32'(m_mode == 2));
  endtask
  task automatic go_locked();
    f_slow = 0;
    f_fast = 0;
    tdc_valid = 1;
    tdc_val = 8'd3;
    lock_thresh = 8'd4;
    lock_count = 8'd8;
    repeat (SETTLE + 8) cyc();
    chk("go_locked", 32'(phase_locked), 32'd1);
  endtask
  initial begin
    int rail_pct;
    rst = 1; enable = 1; tdc_valid = 0; f_slow = 0; f_fast = 0;
    tdc_val = 0; lock_thresh = 8'd4; lock_count = 8'd8; unlock_count = 8'd2;
    repeat (2) cyc();
    chk("rst_err", 32'(lf_err), 32'd0);
    chk("rst_freq", 32'(freq_locked), 32'd0);
    rst = 0;
    f_slow = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("slow_rail", 32'(lf_err), 32'h7f);
      chk("slow_en", 32'(lf_en), 32'd1);
    end
    f_slow = 0; f_fast = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("fast_rail", 32'(lf_err), 32'h80);
    end
    f_fast = 0;
    repeat (9) cyc();
    f_slow = 1; f_fast = 1;
    cyc();
    chk("both_err", 32'(lf_err), 32'd0);
    chk("both_en", 32'(lf_en), 32'd0);
    f_slow = 0; f_fast = 0;
    repeat (15) cyc();
    chk("settle_15", 32'(freq_locked), 32'd0);
    cyc();
    chk("settle_16", 32'(freq_locked), 32'd1);
    tdc_valid = 1; tdc_val = 8'd3;
    repeat (7) cyc();
    chk("lock_7", 32'(phase_locked), 32'd0);
    cyc();
    chk("lock_8", 32'(phase_locked), 32'd1);
    chk("tdc_err", 32'(lf_err), 32'd3);
    tdc_val = 8'h80;
    cyc();
    chk("clip", 32'(lf_err), 32'h81);
    tdc_val = 8'd2; cyc();
    tdc_val = 8'd20; cyc();
    tdc_val = 8'd2; cyc();
    tdc_val = 8'd20; cyc();
    chk("keep_lock", 32'(phase_locked), 32'd1);
    cyc();
    chk("drop_phase", 32'(phase_locked), 32'd0);
    chk("drop_freq", 32'(freq_locked), 32'd1);
    tdc_val = 8'd3;
    repeat (8) cyc();
    chk("relock", 32'(phase_locked), 32'd1);
    tdc_valid = 0; f_fast = 1;
    repeat (3) cyc();
    f_fast = 0; cyc();
    chk("gap_keeps", 32'(phase_locked), 32'd1);
    f_fast = 1;
    repeat (3) cyc();
    chk("slip_3", 32'(freq_locked), 32'd1);
    cyc();
    chk("slip_err", 32'(lf_err), 32'h80);
    chk("slip_en", 32'(lf_en), 32'd1);
    chk("slip_freq", 32'(freq_locked), 32'd0);
    chk("slip_phase", 32'(phase_locked), 32'd0);
    go_locked();
    rst = 1; cyc();
    chk("mid_rst_err", 32'(lf_err), 32'd0);
    chk("mid_rst_freq", 32'(freq_locked), 32'd0);
    chk("mid_rst_phase", 32'(phase_locked), 32'd0);
    rst = 0;
    go_locked();
    enable = 0; tdc_val = 8'd20; f_fast = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("dis_en", 32'(lf_en), 32'd0);
      chk("dis_err", 32'(lf_err), 32'd3);
      chk("dis_phase", 32'(phase_locked), 32'd1);
    end
    enable = 1; f_fast = 0; tdc_val = 8'd3;
    cyc();
    chk("reen_phase", 32'(phase_locked), 32'd1);
    chk("reen_en", 32'(lf_en), 32'd1);
    for (int seg = 0; seg < 40; seg++) begin
      rail_pct = (seg % 3 == 2) ? 60 : 3;
      lock_thresh = 8'($urandom_range(0, 40));
      lock_count = 8'($urandom_range(0, 6));
      unlock_count = 8'($urandom_range(0, 3));
      for (int k = 0; k < 100; k++) begin
        rst = $urandom_range(0, 299) == 0;
        enable = $urandom_range(0, 19) != 0;
        f_slow = $urandom_range(0, 99) < rail_pct;
        f_fast = $urandom_range(0, 99) < rail_pct;
        tdc_valid = $urandom_range(0, 9) < 7;
        tdc_val = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24) - 12);
        if ($urandom_range(0, 49) == 0) lock_count = 8'($urandom_range(0, 6));
        if ($urandom_range(0, 49) == 0) lock_thresh = 8'($urandom_range(0, 40));
        cyc();
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
